// File: rtl/binary_div_12_1_bi.sv
// Signed restoring divider: one capture edge, then ITER shift-subtract edges on
// unsigned magnitudes, with sign correction applied when the result is written.
module binary_div_12_1_bi #(
    parameter int unsigned W    = 12,
    parameter int unsigned ITER = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic         ovf
);

    typedef enum logic {StIdle, StCalc} state_e;

    localparam logic [W-1:0] OneW  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   OneW1 = {{W{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] dvd_q, dvd_d;   // dividend magnitude, shifts out MSB-first; quotient shifts in
    logic [W:0]   dvs_q, dvs_d;   // divisor magnitude, W+1 bits so |min| is exact
    logic [W:0]   rem_q, rem_d;   // partial remainder magnitude
    logic         sa_q, sa_d;
    logic         sb_q, sb_d;
    logic         bz_q, bz_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] r_q, r_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         dz_q, dz_d;
    logic         ovf_q, ovf_d;

    logic [W:0]   a_ext, b_ext, a_mag, b_mag;
    logic [W+1:0] trial, div_ext;
    logic         ge;
    logic [W:0]   rem_step;
    logic [W-1:0] quo_step;
    logic [W-1:0] rem_mag;
    logic         neg_q;
    logic [W-1:0] q_fix, r_fix;

    // Operand magnitudes and one restoring step on the current partial remainder
    always_comb begin
        a_ext    = {A[W-1], A};
        b_ext    = {B[W-1], B};
        a_mag    = a_ext[W] ? (~a_ext + OneW1) : a_ext;
        b_mag    = b_ext[W] ? (~b_ext + OneW1) : b_ext;
        trial    = {rem_q, dvd_q[W-1]};
        div_ext  = {1'b0, dvs_q};
        ge       = (trial >= div_ext);
        rem_step = ge ? (W+1)'(trial - div_ext) : (W+1)'(trial);
        quo_step = {dvd_q[W-2:0], ge};
        rem_mag  = W'(rem_step);
        neg_q    = sa_q ^ sb_q;
        q_fix    = neg_q ? (~quo_step + OneW) : quo_step;
        // With a zero divisor every step subtracts nothing, so the remainder ends
        // up holding |A| and r_fix reproduces A without a separate path.
        r_fix    = sa_q ? (~rem_mag + OneW) : rem_mag;
    end

    // Next-state: capture in idle, iterate in calc, publish results on the last step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                    busy_d  = 1'b1;
                    dvd_d   = W'(a_mag);
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    sa_d    = A[W-1];
                    sb_d    = B[W-1];
                    bz_d    = (B == '0);
                    cnt_d   = 4'(ITER - 1);
                end
            end
            StCalc: begin
                dvd_d = quo_step;
                rem_d = rem_step;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = bz_q ? '0 : q_fix;
                    r_d     = r_fix;
                    dz_d    = bz_q;
                    // Only -min/-1 yields a positive quotient with the sign bit set
                    ovf_d   = !bz_q && !neg_q && quo_step[W-1];
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers: async reset, everything frozen while en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_binary_div_12_1_bi.sv
// Directed and randomized checks of the signed divider against an arithmetic model.
module tb_binary_div_12_1_bi;

    localparam int W = 12;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         en    = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic [W-1:0] Q, R;
    logic         busy, done, dz, ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_div_12_1_bi #(.W(W), .ITER(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed division truncating toward zero, remainder follows dividend
    function automatic void model(input int a, input int b, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic fdz, output logic fovf);
        fdz  = 1'b0;
        fovf = 1'b0;
        if (b == 0) begin
            q   = '0;
            r   = W'(a);
            fdz = 1'b1;
        end else if (a == -2048 && b == -1) begin
            q    = W'(-2048);
            r    = '0;
            fovf = 1'b1;
        end else begin
            q = W'(a / b);
            r = W'(a % b);
        end
    endfunction

    // Present operands with start for one edge, then scramble the operand inputs
    task automatic launch(input int a, input int b);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic expect_result(input string tag, input int a, input int b);
        logic [W-1:0] eq, er;
        logic         edz, eovf;
        model(a, b, eq, er, edz, eovf);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_q"},    32'(Q),    32'(eq));
        chk({tag, "_r"},    32'(R),    32'(er));
        chk({tag, "_dz"},   32'(dz),   32'(edz));
        chk({tag, "_ovf"},  32'(ovf),  32'(eovf));
    endtask

    task automatic divide(input string tag, input int a, input int b);
        int n;
        launch(a, b);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'd12);
        expect_result(tag, a, b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"},    32'(Q),    32'd0);
        chk({tag, "_r"},    32'(R),    32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_dz"},   32'(dz),   32'd0);
        chk({tag, "_ovf"},  32'(ovf),  32'd0);
    endtask

    initial begin
        int n, n_en, g, hits, a, b, sel;

        // Reset state
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk); #1;
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic division and done pulse width
        divide("d100_7", 100, 7);
        @(posedge clk); #1;
        chk("d100_7_done_clear", 32'(done), 32'd0);
        chk("d100_7_q_hold", 32'(Q), 32'd14);

        // Sign combinations
        divide("dm100_7", -100, 7);
        divide("d100_m7", 100, -7);
        divide("dm100_m7", -100, -7);
        divide("d2047_m1", 2047, -1);

        // Boundaries
        divide("d5_0", 5, 0);
        divide("dm2048_0", -2048, 0);
        divide("dm2048_2047", -2048, 2047);
        divide("dm2048_1", -2048, 1);
        divide("d0_m3", 0, -3);

        // Clock-enable gap plus ignored start pulses while busy
        launch(100, 7);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            en    = (n >= 3 && n < 6) ? 1'b0 : 1'b1;
            start = (n == 1 || n == 7) ? 1'b1 : 1'b0;
            A     = W'(-999);
            B     = W'(3);
            @(posedge clk); #1;
            n++;
            if (n == 4) begin
                chk("engap_busy", 32'(busy), 32'd1);
                chk("engap_done", 32'(done), 32'd0);
            end
        end
        en    = 1'b1;
        start = 1'b0;
        chk("engap_lat", 32'(n), 32'd15);
        expect_result("engap", 100, 7);

        // Back-to-back: new start accepted in the done cycle
        divide("b2b_first", -100, 7);
        launch(37, -5);
        chk("b2b_done_clear", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_lat", 32'(n), 32'd12);
        expect_result("b2b_second", 37, -5);

        // Overflow result then reset mid-division
        divide("dm2048_m1", -2048, -1);
        launch(100, 7);
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        #3 rst_n = 1'b1;
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) hits++;
        end
        chk("midrst_no_done", 32'(hits), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        divide("after_rst", 100, 7);

        // Randomized divisions with enable gaps, stray starts and operand noise
        repeat (300) begin
            a   = ($urandom_range(0, 7) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       b = 0;
                1:       b = -1;
                2:       b = 1;
                3:       b = -2048;
                default: b = int'($urandom_range(0, 4095)) - 2048;
            endcase
            launch(a, b);
            n_en = 0;
            g    = 0;
            while (done !== 1'b1 && g < 200) begin
                en    = ($urandom_range(0, 4) != 0);
                start = 1'($urandom_range(0, 1));
                A     = W'($urandom);
                B     = W'($urandom);
                @(posedge clk);
                if (en) n_en++;
                #1;
                g++;
            end
            en    = 1'b1;
            start = 1'b0;
            chk("rand_lat", 32'(n_en), 32'd12);
            expect_result("rand", a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
